// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, unsigned N-bit operands.
// Quotient/remainder/div_zero are registered and only change when an operation completes.
module div_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_zero_o
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   dq_q, dq_d, dv_q, dv_d, pr_q, pr_d;
    logic [N-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dz_q, dz_d;
    logic [N:0]     t;
    logic [N-1:0]   t_sub, pr_nx, dq_nx;
    logic           ge, last, div0;

    // The partial remainder never reaches 2^N (it stays below the divisor),
    // so only the trial value needs the extra bit for the compare.
    always_comb begin
        t     = {pr_q, dq_q[N-1]};
        ge    = t >= {1'b0, dv_q};
        t_sub = t[N-1:0] - dv_q;
        pr_nx = ge ? t_sub : t[N-1:0];
        dq_nx = {dq_q[N-2:0], ge};
        last  = cnt_q == CW'(N - 1);
        div0  = dv_q == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A zero divisor spends its one CALC cycle loading the saturated result,
    // which puts its done strobe one edge after the accepted start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CALC;
            CALC:    if (div0 || last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_q != IDLE;
        done_o = state_q == DONE;
    end

    always_comb begin
        dq_d   = dq_q;
        dv_d   = dv_q;
        pr_d   = pr_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        if (state_q == IDLE && start_i) begin
            dq_d  = dividend_i;
            dv_d  = divisor_i;
            pr_d  = '0;
            cnt_d = '0;
        end else if (state_q == CALC) begin
            if (div0) begin
                quot_d = '1;
                rem_d  = dq_q;
                dz_d   = 1'b1;
            end else begin
                dq_d  = dq_nx;
                pr_d  = pr_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    quot_d = dq_nx;
                    rem_d  = pr_nx;
                    dz_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_q   <= '0;
            dv_q   <= '0;
            pr_q   <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            dv_q   <= dv_d;
            pr_q   <= pr_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign div_zero_o  = dz_q;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: N=8 directed/sweep/disturbance/reset stream and
// an independent N=16 back-to-back random stream; expectations come from / and %.
module tb_div_seq;
    logic clk = 1'b0, rst_n, rst16;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s8, busy8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;
    logic        s16, busy16, done16, dz16;
    logic [15:0] a16, b16, q16, r16;
    bit          fin16 = 0;

    div_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(s8), .dividend_i(a8), .divisor_i(b8),
        .busy_o(busy8), .done_o(done8), .quotient_o(q8), .remainder_o(r8), .div_zero_o(dz8));

    div_seq #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst16), .start_i(s16), .dividend_i(a16), .divisor_i(b16),
        .busy_o(busy16), .done_o(done16), .quotient_o(q16), .remainder_o(r16), .div_zero_o(dz16));

    typedef struct {
        logic [15:0] q, r, a, b;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb8[$], sb16[$];
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b, input int n, input int c);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q  = 16'hFFFF >> (16 - n);
            e.r  = a;
            e.dz = 1'b1;
            e.cyc = c + 2;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
            e.cyc = c + 1 + n;
        end
        return e;
    endfunction

    // N=8 monitor: scoreboard compare, one-cycle done, results held between completions
    exp_t       e8;
    logic       pd8 = 0;
    logic [7:0] held8 = 0;
    always @(negedge clk) begin
        if (!rst_n) held8 <= '0;
        else if (done8) begin
            chk("done_1cyc8", {31'd0, pd8}, 0);
            if (sb8.size() == 0) chk("spurious_done8", 1, 0);
            else begin
                e8 = sb8.pop_front();
                chk("quot8", {24'd0, q8}, {16'd0, e8.q});
                chk("rem8", {24'd0, r8}, {16'd0, e8.r});
                chk("dz8", {31'd0, dz8}, {31'd0, e8.dz});
                chk("lat8", cyc, e8.cyc);
            end
            held8 <= q8;
        end else chk("hold_q8", {24'd0, q8}, {24'd0, held8});
        pd8 <= done8;
    end

    exp_t e16;
    logic pd16 = 0;
    always @(negedge clk) begin
        if (rst16 && done16) begin
            chk("done_1cyc16", {31'd0, pd16}, 0);
            if (sb16.size() == 0) chk("spurious_done16", 1, 0);
            else begin
                e16 = sb16.pop_front();
                chk("quot16", {16'd0, q16}, {16'd0, e16.q});
                chk("rem16", {16'd0, r16}, {16'd0, e16.r});
                chk("dz16", {31'd0, dz16}, {31'd0, e16.dz});
                chk("lat16", cyc, e16.cyc);
                if (e16.b != 0) begin
                    chk("inv16", 32'(q16) * 32'(e16.b) + 32'(r16), {16'd0, e16.a});
                    chk("rem_lt16", {31'd0, r16 < e16.b}, 1);
                end
            end
        end
        pd16 <= done16;
    end

    // Called at a negedge with busy8 low; returns at the negedge where busy8 is low again.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit poke);
        int n = 0;
        int exp_busy = (b == 0) ? 2 : 9;
        a8 = a; b8 = b; s8 = 1'b1;
        sb8.push_back(mk({8'd0, a}, {8'd0, b}, 8, cyc));
        do begin
            @(negedge clk);
            s8 = 1'b0;
            n++;
            if (poke && n == 3) begin s8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); end
            if (poke && n == exp_busy) s8 = 1'b1;
        end while (busy8 && n < 40);
        s8 = 1'b0;
        chk("busy_len8", n - 1, exp_busy);
    endtask

    initial begin
        rst_n = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        #3;
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_done", {31'd0, done8}, 0);
        chk("rst_q", {24'd0, q8}, 0);
        chk("rst_r", {24'd0, r8}, 0);
        chk("rst_dz", {31'd0, dz8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(100, 7, 0);
        op8(255, 1, 0);
        op8(5, 9, 0);
        op8(255, 255, 0);
        op8(0, 3, 0);
        op8(37, 0, 0);
        op8(9, 3, 0);
        op8(100, 7, 1);
        op8(200, 13, 1);
        op8(77, 0, 0);

        // abort 100/7 a few iterations in
        a8 = 100; b8 = 7; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy8}, 0);
        chk("abort_done", {31'd0, done8}, 0);
        chk("abort_q", {24'd0, q8}, 0);
        chk("abort_r", {24'd0, r8}, 0);
        chk("abort_dz", {31'd0, dz8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        op8(100, 7, 0);

        for (int b = 0; b < 256; b++) op8(8'($urandom), 8'(b), b[4]);
        repeat (200) op8(8'($urandom), ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom), 0);

        for (int i = 0; i < 20000 && !fin16; i++) @(negedge clk);
        if (!fin16) chk("timeout16", 0, 1);
        repeat (3) @(negedge clk);
        chk("sb8_empty", sb8.size(), 0);
        chk("sb16_empty", sb16.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        int n, exp_busy;
        logic [15:0] a, b;
        rst16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        rst16 = 1'b1;
        @(negedge clk);
        repeat (300) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
            exp_busy = (b == 0) ? 2 : 17;
            a16 = a; b16 = b; s16 = 1'b1;
            sb16.push_back(mk(a, b, 16, cyc));
            n = 0;
            do begin
                @(negedge clk);
                s16 = 1'b0;
                n++;
            end while (busy16 && n < 60);
            chk("busy_len16", n - 1, exp_busy);
        end
        fin16 = 1;
    end
endmodule
